oam_dma_ctrl: RTL and testbench
===============================

# oam_dma_ctrl

Sprite-DMA sequencer for the NES CPU bus. It watches CPU writes to the DMA page register ($4014), then halts the 6502 through `rdy` and takes ownership of the CPU address/data bus. While it owns the bus it copies 256 bytes from CPU page `$XX00–$XXFF` to the PPU OAM data port ($2004). It sits between the CPU core and the memory/IO decoder and drives the bus mux select.

## Interface
Parameters:
- `DMA_REG_ADDR`, 16'h4014, CPU address that triggers a transfer.
- `OAM_DATA_ADDR`, 16'h2004, destination address for every DMA write.
- `XFER_LEN`, 256, bytes per transfer; power of two, max 256.

Ports:
- `clk` in 1: system clock. One clock; all logic is on its rising edge.
- `b_rst` in 1: reset, synchronous and active-high (1 = reset).
- `cpu_ce` in 1: CPU-cycle enable, one `clk` pulse per CPU cycle.
- `cpu_addr_out` in 16: CPU address.
- `cpu_data_out` in 8: CPU write data.
- `wen` in 1: CPU write strobe.
- `cpu_data_in` in 8: memory read data, valid at the `cpu_ce` that ends a read cycle.
- `rdy` out 1: CPU ready; 0 halts the CPU.
- `bus_sel` out 1: 1 = DMA drives the bus.
- `dma_addr` out 16: DMA bus address.
- `dma_data` out 8: DMA write data.
- `dma_ren` out 1: DMA read strobe.
- `dma_wen` out 1: DMA write strobe.
- `busy` out 1: transfer in progress.

## Operation
- States: IDLE, HALT, ALIGN, READ, WRITE.
- Parity flag `put`: toggles on every `cpu_ce`; reset value 0. Parity 0 = get cycle, parity 1 = put cycle.
- Trigger: in IDLE, `cpu_ce & wen & cpu_addr_out==DMA_REG_ADDR` does all of the following:
  - latches `page <= cpu_data_out`;
  - sets `idx <= 0`;
  - moves to HALT;
  - sets `rdy <= 0` and `busy <= 1`.
- HALT: lasts one CPU cycle with no strobes. On exit, goes to ALIGN if the next cycle is a put cycle; otherwise goes to READ.
- ALIGN: lasts one CPU cycle with no strobes, then goes to READ.
- READ:
  - `bus_sel=1`, `dma_addr={page,idx}`, `dma_ren=1`.
  - At the ending `cpu_ce`, latches `dma_data <= cpu_data_in` and goes to WRITE.
- WRITE:
  - `bus_sel=1`, `dma_addr=OAM_DATA_ADDR`, `dma_wen=1`, `dma_data` held.
  - At the ending `cpu_ce`, `idx <= idx+1` (8-bit).
  - If `idx==XFER_LEN-1`, goes to IDLE and drops `bus_sel`; otherwise goes to READ.
- Leaving WRITE for IDLE sets `rdy=1` and `busy=0`.
- Strobes are levels held for the whole CPU cycle; they are decoded from state, not from `cpu_ce`.
- With `cpu_ce=0`, the state, `idx`, `put` and all outputs hold.
- A write to `DMA_REG_ADDR` while not IDLE is ignored and does not change `page`.
- Trigger and `b_rst` in the same clock: reset wins.
- `b_rst` mid-transfer: on the next edge the block is in IDLE with all outputs at reset values. There are no partial writes after reset.
- Reset values: `rdy=1`, `bus_sel=0`, `dma_ren=0`, `dma_wen=0`, `dma_addr=0`, `dma_data=0`, `busy=0`, `idx=0`, `page=0`, `put=0`.

## Timing
- Trigger write on CPU cycle W with parity p.
  - HALT is cycle W+1.
  - p=0: first READ at W+2; `rdy` is low for 513 CPU cycles.
  - p=1: ALIGN at W+2 and first READ at W+3; `rdy` is low for 514 CPU cycles.
- `rdy` falls on the `clk` edge of the trigger's `cpu_ce`. It rises on the edge that ends the last WRITE.
- READ always falls on a get cycle (parity 0); WRITE always falls on a put cycle.
- The READ→WRITE data path has a 0-cycle bubble: the byte read in CPU cycle n is written in cycle n+1.

## Configuration
- `OAM_DMA_ALIGN_EN` defined:
  - parity tracking and the ALIGN state are compiled in;
  - transfers take 513 or 514 CPU cycles as above.
- `OAM_DMA_ALIGN_EN` undefined:
  - `put` and ALIGN are removed; HALT always goes to READ;
  - every transfer takes exactly 513 CPU cycles, regardless of parity.

## Test plan
- Memory $0300+i = i^8'hA5. Write $4014=8'h03 on a parity-0 cycle, `cpu_ce` every clk → 256 `dma_wen` pulses at $2004 carrying i^8'hA5 in order, and `rdy` low for exactly 513 cycles.
- Same stimulus triggered on a parity-1 cycle, `OAM_DMA_ALIGN_EN` defined → one extra idle cycle after HALT, and `rdy` low for 514 cycles. With the macro undefined → 513 cycles.
- Assert `b_rst` after the 100th write → next edge `rdy=1`, `bus_sel=0`, `busy=0`, no further strobes. Re-trigger with page 8'h05 → first read is at $0500.
- Write $4014=8'h07 during an active page-8'h02 transfer → still 256 bytes from $02xx, and `page` unchanged.
- `cpu_ce` asserted one clk in four → identical sequence of 256 read/write pairs, exactly one strobe per CPU cycle, and outputs stable between enables.
- Trigger and `b_rst` asserted in the same clk → block stays IDLE with `rdy=1`.

Source files
------------

// File: rtl/oam_dma_if.sv
// CPU-side and DMA-side bus signals between the CPU core and the sprite-DMA sequencer.
// The master modport is the DMA controller; the slave modport is the CPU/memory side.
interface oam_dma_if;
  logic        cpu_ce;
  logic [15:0] cpu_addr_out;
  logic [7:0]  cpu_data_out;
  logic        wen;
  logic [7:0]  cpu_data_in;
  logic        rdy;
  logic        bus_sel;
  logic [15:0] dma_addr;
  logic [7:0]  dma_data;
  logic        dma_ren;
  logic        dma_wen;
  logic        busy;

  modport master (
    input  cpu_ce, cpu_addr_out, cpu_data_out, wen, cpu_data_in,
    output rdy, bus_sel, dma_addr, dma_data, dma_ren, dma_wen, busy
  );

  modport slave (
    output cpu_ce, cpu_addr_out, cpu_data_out, wen, cpu_data_in,
    input  rdy, bus_sel, dma_addr, dma_data, dma_ren, dma_wen, busy
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// NES sprite-DMA sequencer: a CPU write to DMA_REG_ADDR halts the CPU and copies one page to OAM.
// Define OAM_DMA_ALIGN_EN to compile in get/put parity tracking and the ALIGN state.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int unsigned XFER_LEN      = 256
) (
  input logic       clk,
  input logic       b_rst,
  oam_dma_if.master bus
);

  localparam logic [7:0] LastIdx = 8'(XFER_LEN - 1);

  typedef enum logic [2:0] {
    StIdle,
    StHalt,
    StRead,
    StWrite
`ifdef OAM_DMA_ALIGN_EN
    , StAlign
`endif
  } state_e;

  state_e      state_q;
  logic [7:0]  page_q;
  logic [7:0]  idx_q;
  logic        rdy_q;
  logic        busy_q;
  logic        bus_sel_q;
  logic [15:0] dma_addr_q;
  logic [7:0]  dma_data_q;
  logic        dma_ren_q;
  logic        dma_wen_q;
`ifdef OAM_DMA_ALIGN_EN
  logic        put_q;
`endif

  // Everything advances only on cpu_ce, so strobes stay level for a whole CPU cycle.
  always_ff @(posedge clk) begin
    if (b_rst) begin
      state_q    <= StIdle;
      page_q     <= 8'h00;
      idx_q      <= 8'h00;
      rdy_q      <= 1'b1;
      busy_q     <= 1'b0;
      bus_sel_q  <= 1'b0;
      dma_addr_q <= 16'h0000;
      dma_data_q <= 8'h00;
      dma_ren_q  <= 1'b0;
      dma_wen_q  <= 1'b0;
`ifdef OAM_DMA_ALIGN_EN
      put_q      <= 1'b0;
`endif
    end else if (bus.cpu_ce) begin
`ifdef OAM_DMA_ALIGN_EN
      put_q <= ~put_q;
`endif
      unique case (state_q)
        StIdle: begin
          if (bus.wen && (bus.cpu_addr_out == DMA_REG_ADDR)) begin
            page_q  <= bus.cpu_data_out;
            idx_q   <= 8'h00;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StHalt;
          end
        end
        StHalt: begin
`ifdef OAM_DMA_ALIGN_EN
          // put_q is this cycle's parity; a get here means the next cycle is a put.
          if (!put_q) begin
            state_q <= StAlign;
          end else begin
            state_q    <= StRead;
            bus_sel_q  <= 1'b1;
            dma_addr_q <= {page_q, idx_q};
            dma_ren_q  <= 1'b1;
          end
`else
          state_q    <= StRead;
          bus_sel_q  <= 1'b1;
          dma_addr_q <= {page_q, idx_q};
          dma_ren_q  <= 1'b1;
`endif
        end
`ifdef OAM_DMA_ALIGN_EN
        StAlign: begin
          state_q    <= StRead;
          bus_sel_q  <= 1'b1;
          dma_addr_q <= {page_q, idx_q};
          dma_ren_q  <= 1'b1;
        end
`endif
        StRead: begin
          dma_data_q <= bus.cpu_data_in;
          dma_addr_q <= OAM_DATA_ADDR;
          dma_ren_q  <= 1'b0;
          dma_wen_q  <= 1'b1;
          state_q    <= StWrite;
        end
        StWrite: begin
          idx_q     <= idx_q + 8'd1;
          dma_wen_q <= 1'b0;
          if (idx_q == LastIdx) begin
            state_q    <= StIdle;
            bus_sel_q  <= 1'b0;
            dma_addr_q <= 16'h0000;
            rdy_q      <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            state_q    <= StRead;
            dma_addr_q <= {page_q, idx_q + 8'd1};
            dma_ren_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.rdy      = rdy_q;
  assign bus.busy     = busy_q;
  assign bus.bus_sel  = bus_sel_q;
  assign bus.dma_addr = dma_addr_q;
  assign bus.dma_data = dma_data_q;
  assign bus.dma_ren  = dma_ren_q;
  assign bus.dma_wen  = dma_wen_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: random memory and pages, per-CPU-cycle bus monitor,
// expectations computed from the transfer rules (byte i of page P lands at OAM in order).
module tb_oam_dma_ctrl;
  logic clk = 1'b0;
  logic b_rst;
  oam_dma_if bus ();

  oam_dma_ctrl dut (
    .clk  (clk),
    .b_rst(b_rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  assign bus.cpu_data_in = mem[bus.dma_addr];

  int checks = 0;
  int errors = 0;
  int ce_div = 1;

  // Monitor state: one record per CPU cycle, taken on the falling edge before the ending edge.
  int unsigned ce_count = 0;
  int          cyc_cnt  = 0;
  int          rdy_low  = 0;
  int          bad      = 0;
  int          par_err  = 0;
  int          stab_err = 0;
  logic [15:0] rd_q[$];
  int          rd_cyc_q[$];
  logic [7:0]  wr_q[$];
  logic        ce_prev  = 1'b0;
  logic        rst_prev = 1'b1;
  logic [28:0] snap     = '0;
  wire  [28:0] outs = {bus.rdy, bus.bus_sel, bus.dma_addr, bus.dma_data, bus.dma_ren,
                       bus.dma_wen, bus.busy};

  always @(posedge clk) begin
    if (b_rst) ce_count <= 0;
    else if (bus.cpu_ce) ce_count <= ce_count + 1;
  end

  always @(negedge clk) begin
    if (!ce_prev && !rst_prev && (outs !== snap)) stab_err <= stab_err + 1;
    snap     <= outs;
    ce_prev  <= bus.cpu_ce;
    rst_prev <= b_rst;
    if (bus.cpu_ce && !b_rst) begin
      cyc_cnt <= cyc_cnt + 1;
      if (!bus.rdy) rdy_low <= rdy_low + 1;
      if (bus.dma_ren) begin
        rd_q.push_back(bus.dma_addr);
        rd_cyc_q.push_back(cyc_cnt);
      end
      if (bus.dma_wen) wr_q.push_back(bus.dma_data);
      if ((bus.dma_ren && (bus.dma_wen || !bus.bus_sel)) ||
          (bus.dma_wen && (!bus.bus_sel || bus.dma_addr != 16'h2004)))
        bad <= bad + 1;
      if ((bus.dma_ren && ce_count[0]) || (bus.dma_wen && !ce_count[0])) par_err <= par_err + 1;
    end
  end

  task automatic step(input logic w, input logic [15:0] a, input logic [7:0] d);
    for (int k = 0; k < ce_div - 1; k++) begin
      bus.cpu_ce = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.cpu_ce       = 1'b1;
    bus.wen          = w;
    bus.cpu_addr_out = a;
    bus.cpu_data_out = d;
    @(posedge clk);
    #1;
    bus.cpu_ce = 1'b0;
    bus.wen    = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 16'($urandom), 8'($urandom));
  endtask

  task automatic wait_done(output bit timeout);
    timeout = 1'b1;
    for (int n = 0; n < 600; n++) begin
      idle();
      if (!bus.busy) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    b_rst = 1'b1;
    bus.cpu_ce = 1'b0; bus.wen = 1'b0; bus.cpu_addr_out = 16'h0; bus.cpu_data_out = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    b_rst = 1'b0;
    checks++; if (bus.rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b want 1", bus.rdy); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.bus_sel !== 1'b0) begin errors++; $display("FAIL reset_bus_sel got %b want 0", bus.bus_sel); end
    checks++; if (bus.dma_ren !== 1'b0) begin errors++; $display("FAIL reset_ren got %b want 0", bus.dma_ren); end
    checks++; if (bus.dma_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %b want 0", bus.dma_wen); end
    checks++; if (bus.dma_addr !== 16'h0) begin errors++; $display("FAIL reset_addr got %h want 0000", bus.dma_addr); end
    checks++; if (bus.dma_data !== 8'h0) begin errors++; $display("FAIL reset_data got %h want 00", bus.dma_data); end
  endtask

  task automatic test_transfers();
    logic [7:0] pg_t [5];
    int par_t [5];
    int div_t [5];
    pg_t = '{8'h03, 8'h03, 8'($urandom), 8'($urandom), 8'($urandom)};
    par_t = '{0, 1, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1))};
    div_t = '{1, 1, 1, 1, 4};
    for (int s = 0; s < 5; s++) begin
      int rb, wb, lb, w, p, exp_len, exp_first, first, nd, na;
      bit to;
      ce_div = div_t[s];
      if (int'(ce_count[0]) != par_t[s]) idle();
      rb = rd_q.size(); wb = wr_q.size(); lb = rdy_low; w = cyc_cnt; p = int'(ce_count[0]);
      step(1'b1, 16'h4014, pg_t[s]);
      wait_done(to);
      idle(); idle();
      exp_len = 513; exp_first = w + 2;
`ifdef OAM_DMA_ALIGN_EN
      if (p == 1) begin exp_len = 514; exp_first = w + 3; end
`endif
      nd = 0; na = 0;
      for (int i = 0; i < 256; i++) begin
        if (wb + i >= wr_q.size() || wr_q[wb + i] !== mem[{pg_t[s], 8'(i)}]) nd++;
        if (rb + i >= rd_q.size() || rd_q[rb + i] !== {pg_t[s], 8'(i)}) na++;
      end
      first = (rd_q.size() > rb) ? rd_cyc_q[rb] : -1;
      checks++; if (to) begin errors++; $display("FAIL xfer%0d_done got busy want idle", s); end
      checks++; if (wr_q.size() - wb != 256) begin errors++; $display("FAIL xfer%0d_nwrites got %0d want 256", s, wr_q.size() - wb); end
      checks++; if (rd_q.size() - rb != 256) begin errors++; $display("FAIL xfer%0d_nreads got %0d want 256", s, rd_q.size() - rb); end
      checks++; if (nd != 0) begin errors++; $display("FAIL xfer%0d_data got %0d bad bytes want 0", s, nd); end
      checks++; if (na != 0) begin errors++; $display("FAIL xfer%0d_raddr got %0d bad addrs want 0", s, na); end
      checks++; if (rdy_low - lb != exp_len) begin errors++; $display("FAIL xfer%0d_rdy_low got %0d want %0d", s, rdy_low - lb, exp_len); end
      checks++; if (first != exp_first) begin errors++; $display("FAIL xfer%0d_first_read got %0d want %0d", s, first, exp_first); end
    end
    ce_div = 1;
  endtask

  task automatic test_retrigger_ignored();
    int rb, wb, na, nd;
    bit to;
    rb = rd_q.size(); wb = wr_q.size(); to = 1'b1;
    step(1'b1, 16'h4014, 8'h02);
    for (int n = 0; n < 600; n++) begin
      if (n == 50) step(1'b1, 16'h4014, 8'h07);
      else idle();
      if (!bus.busy) begin to = 1'b0; break; end
    end
    repeat (3) idle();
    na = 0; nd = 0;
    for (int i = 0; i < 256; i++) begin
      if (rb + i >= rd_q.size() || rd_q[rb + i] !== {8'h02, 8'(i)}) na++;
      if (wb + i >= wr_q.size() || wr_q[wb + i] !== mem[{8'h02, 8'(i)}]) nd++;
    end
    checks++; if (to) begin errors++; $display("FAIL retrig_done got busy want idle"); end
    checks++; if (rd_q.size() - rb != 256) begin errors++; $display("FAIL retrig_nreads got %0d want 256", rd_q.size() - rb); end
    checks++; if (na != 0) begin errors++; $display("FAIL retrig_page got %0d bad addrs want 0", na); end
    checks++; if (nd != 0) begin errors++; $display("FAIL retrig_data got %0d bad bytes want 0", nd); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL retrig_restart got busy %b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    int rb, wb, wb2, rb2;
    bit to;
    rb = rd_q.size(); wb = wr_q.size();
    step(1'b1, 16'h4014, 8'($urandom));
    for (int n = 0; n < 400 && (wr_q.size() - wb) < 100; n++) idle();
    b_rst = 1'b1; bus.cpu_ce = 1'b1;
    @(posedge clk);
    #1;
    b_rst = 1'b0; bus.cpu_ce = 1'b0;
    checks++; if (bus.rdy !== 1'b1) begin errors++; $display("FAIL rstmid_rdy got %b want 1", bus.rdy); end
    checks++; if (bus.bus_sel !== 1'b0) begin errors++; $display("FAIL rstmid_bus_sel got %b want 0", bus.bus_sel); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
    checks++; if (bus.dma_ren !== 1'b0 || bus.dma_wen !== 1'b0) begin errors++; $display("FAIL rstmid_strobes got %b%b want 00", bus.dma_ren, bus.dma_wen); end
    wb2 = wr_q.size(); rb2 = rd_q.size();
    repeat (10) idle();
    checks++; if (wr_q.size() - wb != 100) begin errors++; $display("FAIL rstmid_nwrites got %0d want 100", wr_q.size() - wb); end
    checks++; if (wr_q.size() != wb2 || rd_q.size() != rb2) begin errors++; $display("FAIL rstmid_quiet got %0d strobes want 0", wr_q.size() - wb2 + rd_q.size() - rb2); end
    rb = rd_q.size();
    step(1'b1, 16'h4014, 8'h05);
    wait_done(to);
    checks++; if (rd_q.size() <= rb || rd_q[rb] !== 16'h0500) begin errors++; $display("FAIL rstmid_reread got %h want 0500", (rd_q.size() > rb) ? rd_q[rb] : 16'hxxxx); end
    checks++; if (rd_q.size() - rb != 256) begin errors++; $display("FAIL rstmid_renreads got %0d want 256", rd_q.size() - rb); end
  endtask

  task automatic test_trigger_with_reset();
    int lb, rb;
    bus.cpu_ce = 1'b1; bus.wen = 1'b1; bus.cpu_addr_out = 16'h4014; bus.cpu_data_out = 8'($urandom);
    b_rst = 1'b1;
    @(posedge clk);
    #1;
    b_rst = 1'b0; bus.cpu_ce = 1'b0; bus.wen = 1'b0;
    checks++; if (bus.rdy !== 1'b1) begin errors++; $display("FAIL trigrst_rdy got %b want 1", bus.rdy); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL trigrst_busy got %b want 0", bus.busy); end
    lb = rdy_low; rb = rd_q.size();
    repeat (5) idle();
    checks++; if (rdy_low != lb || rd_q.size() != rb) begin errors++; $display("FAIL trigrst_idle got %0d halted cycles want 0", rdy_low - lb); end
  endtask

  task automatic test_invariants();
    checks++; if (bad != 0) begin errors++; $display("FAIL strobe_protocol got %0d bad cycles want 0", bad); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL hold_between_ce got %0d changes want 0", stab_err); end
`ifdef OAM_DMA_ALIGN_EN
    checks++; if (par_err != 0) begin errors++; $display("FAIL get_put_parity got %0d bad cycles want 0", par_err); end
`endif
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0300 + i] = 8'(i) ^ 8'hA5;
    test_reset();
    test_transfers();
    test_retrigger_ignored();
    test_reset_mid();
    test_trigger_with_reset();
    test_invariants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
